// File: rtl/gf2677_product_gen.sv
// gf2677_product_gen: sequential shift-and-add multiplier feeding the mod-2677
// Barrett reducer. Takes residues a, b over valid/ready, spends AW cycles
// accumulating a*b, then holds the PW-bit product until the consumer takes it.
// Optional feature macro: OPERAND_CHECK_EN adds the op_err output and forces
// the product to 0 when either operand is >= Q.
//
// Handshake: a transfer happens on any posedge where valid && ready are both
// high; valid, once raised by the producer side of this block (out_valid), is
// held with stable data until the matching ready is seen.
module gf2677_product_gen #(
    parameter int Q  = 2677,
    parameter int AW = 12,
    parameter int PW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] product,
`ifdef OPERAND_CHECK_EN
    output logic          op_err,
`endif
    output logic          busy
);

    localparam int CW = (AW > 1) ? $clog2(AW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] acc;
    logic [PW-1:0] mcand;
    logic [AW-1:0] mplr;
    logic [CW-1:0] count;
    logic [PW-1:0] product_q;
    logic [PW-1:0] acc_next;
    logic          last_iter;
`ifdef OPERAND_CHECK_EN
    logic          err_flag;
`endif

    // Next accumulator value for the current MUL iteration (carry discarded).
    always_comb begin
        acc_next  = mplr[0] ? (acc + mcand) : acc;
        last_iter = (count == CW'(AW - 1));
    end

    // Main FSM: accept operands, iterate AW shift-and-add steps, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            count     <= '0;
            product_q <= '0;
`ifdef OPERAND_CHECK_EN
            err_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= {{(PW-AW){1'b0}}, a};
                        mplr  <= b;
                        acc   <= '0;
                        count <= '0;
`ifdef OPERAND_CHECK_EN
                        err_flag <= (32'(a) >= 32'(Q)) || (32'(b) >= 32'(Q));
`endif
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        // The result register holds the last product across
                        // IDLE and the next MUL, so the reducer input never
                        // shows partial sums.
`ifdef OPERAND_CHECK_EN
                        product_q <= err_flag ? '0 : acc_next;
`else
                        product_q <= acc_next;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and status outputs are pure decodes of the registered state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        product   = product_q;
`ifdef OPERAND_CHECK_EN
        op_err    = (state == DONE) && err_flag;
`endif
    end

endmodule

// File: tb/tb_gf2677_product_gen.sv
// Directed bench for gf2677_product_gen: reset, exact products, latency,
// backpressure, mid-operation reset and the optional operand check.
module tb_gf2677_product_gen;

    localparam int AW = 12;
    localparam int PW = 23;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;
`ifdef OPERAND_CHECK_EN
    logic          op_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    gf2677_product_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
`ifdef OPERAND_CHECK_EN
        .op_err    (op_err),
`endif
        .busy      (busy)
    );

    // Clock block
    always #5 clk = ~clk;

    // Checking task
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: wait for in_ready (bounded), present one operand pair for one edge.
    task automatic accept(input logic [AW-1:0] av, input logic [AW-1:0] bv, input string tag);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        tick();
        in_valid = 1'b0;
        a        = $urandom_range(0, 4095);
        b        = $urandom_range(0, 4095);
    endtask

    // Count edges from the accepting edge until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Full transaction with out_ready already high.
    task automatic do_mul(input logic [AW-1:0] av, input logic [AW-1:0] bv,
                          input logic [31:0] exp, input string tag);
        int lat;
        accept(av, bv, tag);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'd12);
        check({tag, "_product"}, 32'(product), exp);
        tick();
        check({tag, "_idle_after"}, 32'(in_ready), 32'd1);
        check({tag, "_held"}, 32'(product), exp);
    endtask

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        // T1 reset
        repeat (3) tick();
        rst = 1'b0;
        check("t1_in_ready", 32'(in_ready), 32'd1);
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_product", 32'(product), 32'd0);
`ifdef OPERAND_CHECK_EN
        check("t1_op_err", 32'(op_err), 32'd0);
`endif

        // T2 largest residues
        do_mul(12'd2676, 12'd2676, 32'd7160976, "t2");

        // T3 assorted products
        do_mul(12'd0, 12'd1234, 32'd0, "t3a");
        do_mul(12'd1234, 12'd2000, 32'd2468000, "t3b");
        do_mul(12'd1, 12'd2676, 32'd2676, "t3c");

        // T4 backpressure
        out_ready = 1'b0;
        accept(12'd100, 12'd27, "t4");
        wait_done(lat);
        check("t4_latency", 32'(lat), 32'd12);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_product", 32'(product), 32'd2700);
            check("t4_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("t4_release_in_ready", 32'(in_ready), 32'd1);
        check("t4_release_valid", 32'(out_valid), 32'd0);

        // T5 reset mid-multiply (count==5 after five MUL edges)
        accept(12'd2000, 12'd2000, "t5");
        repeat (5) tick();
        check("t5_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_product", 32'(product), 32'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("t5_no_valid", 32'(seen), 32'd0);
        do_mul(12'd3, 12'd4, 32'd12, "t5_next");

        // T6 out-of-range operand
`ifdef OPERAND_CHECK_EN
        accept(12'd3000, 12'd2, "t6");
        out_ready = 1'b0;
        wait_done(lat);
        check("t6_latency", 32'(lat), 32'd12);
        check("t6_op_err", 32'(op_err), 32'd1);
        check("t6_product", 32'(product), 32'd0);
        out_ready = 1'b1;
        tick();
        check("t6_op_err_idle", 32'(op_err), 32'd0);
        accept(12'd5, 12'd6, "t6b");
        wait_done(lat);
        check("t6b_op_err", 32'(op_err), 32'd0);
        check("t6b_product", 32'(product), 32'd30);
        tick();
`else
        do_mul(12'd3000, 12'd2, 32'd6000, "t6");
        do_mul(12'd4095, 12'd4095, 32'd16769025 % 32'd8388608, "t6_trunc");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
